// File: rtl/g_reg_bus_pkg.sv
// Shared definitions for the sysclk register bus: address map, FSM states,
// and the command legality check used by the bus master.
package g_reg_bus_pkg;

  localparam logic [4:0] G_REG_ADDR_00 = 5'h00, G_REG_ADDR_01 = 5'h01, G_REG_ADDR_02 = 5'h02;
  localparam logic [4:0] G_REG_ADDR_03 = 5'h03, G_REG_ADDR_04 = 5'h04, G_REG_ADDR_05 = 5'h05;
  localparam logic [4:0] G_REG_ADDR_06 = 5'h06, G_REG_ADDR_07 = 5'h07, G_REG_ADDR_08 = 5'h08;
  localparam logic [4:0] G_REG_ADDR_09 = 5'h09, G_REG_ADDR_0A = 5'h0A, G_REG_ADDR_0B = 5'h0B;
  localparam logic [4:0] G_REG_ADDR_0C = 5'h0C, G_REG_ADDR_0D = 5'h0D, G_REG_ADDR_0E = 5'h0E;
  localparam logic [4:0] G_REG_ADDR_0F = 5'h0F, G_REG_ADDR_10 = 5'h10, G_REG_ADDR_11 = 5'h11;
  localparam logic [4:0] G_REG_ADDR_12 = 5'h12, G_REG_ADDR_13 = 5'h13, G_REG_ADDR_14 = 5'h14;
  localparam logic [4:0] G_REG_ADDR_15 = 5'h15, G_REG_ADDR_16 = 5'h16, G_REG_ADDR_17 = 5'h17;

  localparam logic [4:0] G_REG_ADDR_MAX = 5'b10111;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} g_bus_state_e;

  // Out-of-map address, or a paired write whose odd partner would not exist.
  function automatic logic cmd_illegal(input logic wr, input logic pair, input logic [4:0] addr);
    return (addr > G_REG_ADDR_MAX) || (wr && pair && addr[0]);
  endfunction

endpackage

// File: rtl/g_reg_bus_phase_cnt.sv
// 4-bit loadable down-counter timing the SETUP/STROBE/HOLD phases; saturates at zero.
module g_reg_bus_phase_cnt (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n)              cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != 0)  cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/g_reg_bus_master.sv
// Register-bus initiator: serialises read/write commands onto the active-low strobe bus.
// G_REG_BUS_MASTER_RDBACK_EN: follow every successful write with a readback of the same address.
module g_reg_bus_master
  import g_reg_bus_pkg::*;
#(
  parameter int SETUP_CYC     = 1,
  parameter int RD_STROBE_CYC = 2,
  parameter int HOLD_CYC      = 1
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_addr,
  input  logic        cmd_pair,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        g_wrb,
  output logic        g_rdb,
  output logic [4:0]  g_dout_w0x0f,
  output logic [63:0] din,
  output logic        n9_bit_write,
  input  logic [31:0] g_dout
);

`ifdef G_REG_BUS_MASTER_RDBACK_EN
  localparam bit RDBACK = 1'b1;
`else
  localparam bit RDBACK = 1'b0;
`endif

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] RD_LD    = 4'(RD_STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  g_bus_state_e state;
  logic         rd_phase;   // current access is a read (plain read or write readback)
  logic         cnt_load, cnt_dec, cnt_zero;
  logic [3:0]   cnt_val;
  logic         to_rdback;

  assign to_rdback = RDBACK && !rd_phase;
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign cnt_dec   = (state inside {SETUP, STROBE, HOLD});

  g_reg_bus_phase_cnt u_phase_cnt (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Counter reload for the phase about to start; a write strobe is always one cycle.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE:   if (cmd_valid) begin cnt_load = 1'b1; cnt_val = SETUP_LD; end
      SETUP:  if (cnt_zero)  begin cnt_load = 1'b1; cnt_val = rd_phase ? RD_LD : 4'd0; end
      STROBE: if (cnt_zero)  begin cnt_load = 1'b1; cnt_val = (HOLD_CYC != 0) ? HOLD_LD : SETUP_LD; end
      HOLD:   if (cnt_zero)  begin cnt_load = 1'b1; cnt_val = SETUP_LD; end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rd_phase     <= 1'b0;
      g_wrb        <= 1'b1;
      g_rdb        <= 1'b1;
      g_dout_w0x0f <= '0;
      din          <= '0;
      n9_bit_write <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          g_dout_w0x0f <= cmd_addr;
          din          <= cmd_write ? cmd_data : 64'h0;
          n9_bit_write <= cmd_write & cmd_pair;
          rsp_data     <= '0;
          rd_phase     <= !cmd_write;
          if (cmd_illegal(cmd_write, cmd_pair, cmd_addr)) begin
            rsp_err <= 1'b1;
            state   <= RESP;
          end else begin
            state   <= SETUP;
          end
        end
        SETUP: if (cnt_zero) begin
          state <= STROBE;
          if (rd_phase) g_rdb <= 1'b0;
          else          g_wrb <= 1'b0;
        end
        STROBE: if (cnt_zero) begin
          g_wrb <= 1'b1;
          g_rdb <= 1'b1;
          if (rd_phase) rsp_data <= g_dout;
          if (HOLD_CYC != 0) state <= HOLD;
          else if (to_rdback) begin state <= SETUP; rd_phase <= 1'b1; end
          else state <= RESP;
        end
        HOLD: if (cnt_zero) begin
          if (to_rdback) begin state <= SETUP; rd_phase <= 1'b1; end
          else state <= RESP;
        end
        RESP: if (rsp_ready) begin
          state        <= IDLE;
          n9_bit_write <= 1'b0;
          rsp_err      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
